// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // One extra bit so that a count equal to the full depth is representable.
  function automatic int wcnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Big-endian byte-to-word assembler; word_valid_o is high in the cycle the 4th byte is taken.
module instr_loader_word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        en_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_WORD - 1);

  logic [CW-1:0] r_cnt;
  logic [23:0]   r_shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (en_i) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= {r_shift[15:0], byte_i};
    end
  end

  // The three earlier bytes sit in r_shift; the current byte completes bits 7:0.
  assign word_valid_o = en_i && (r_cnt == LAST_IDX);
  assign word_o       = {r_shift, byte_i};

endmodule

// File: rtl/instr_loader.sv
// Byte-stream instruction loader; holds the CPU until the program is written.
// Optional trailing checksum word enabled by INSTR_LOADER_CHECKSUM_EN.
//
// state   | meaning
// HDR     | collecting the 4-byte word count N
// LOAD    | collecting and writing N data words
// CHK     | collecting checksum word C (checksum build only)
// DONE    | program loaded, CPU released (terminal)
// ERR     | load rejected, CPU held (terminal)
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int KW = wcnt_width(DEPTH_WORDS);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  state_t        r_state, w_state_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_we, w_we_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [31:0]   r_data, w_data_nxt;
  logic          r_hold, w_hold_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [KW-1:0] r_n, w_n_nxt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   r_csum, w_csum_nxt;
`endif

  logic          w_accept;
  logic [31:0]   w_word;
  logic          w_word_valid;

  assign w_accept = byte_valid_i && r_ready;

  instr_loader_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .en_i         (w_accept),
    .word_o       (w_word),
    .word_valid_o (w_word_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_HDR;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_data  <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_n     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_k     <= w_k_nxt;
      r_n     <= w_n_nxt;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_hold_nxt  = r_hold;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
`ifdef INSTR_LOADER_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif

    case (r_state)
      ST_HDR: begin
        if (w_word_valid) begin
          w_n_nxt = w_word[KW-1:0];
`ifdef INSTR_LOADER_CHECKSUM_EN
          w_csum_nxt = w_word;
`endif
          if (w_word == 32'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_state_nxt = ST_DONE;
            w_ready_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
`endif
          end else if (w_word > 32'(DEPTH_WORDS)) begin
            w_state_nxt = ST_ERR;
            w_ready_nxt = 1'b0;
            w_err_nxt   = 1'b1;
            w_hold_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (w_word_valid) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = BASE_ADDR + {30'(r_k), 2'b00};
          w_data_nxt = w_word;
          w_k_nxt    = r_k + K_ONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
          w_csum_nxt = r_csum ^ w_word;
          if (r_k == r_n - K_ONE) begin
            w_state_nxt = ST_CHK;
          end
`else
          if (r_k == r_n - K_ONE) begin
            w_ready_nxt = 1'b0;
          end
`endif
        end
`ifndef INSTR_LOADER_CHECKSUM_EN
        // Release only once the final strobe is on the bus, so the write precedes the first fetch.
        if (r_we && (r_k == r_n)) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_hold_nxt  = 1'b0;
        end
`endif
      end

`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_word_valid) begin
          w_ready_nxt = 1'b0;
          if (w_word == r_csum) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
            w_hold_nxt  = 1'b1;
          end
        end
      end
`endif

      default: ;
    endcase
  end

  assign byte_ready_o = r_ready;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_data;
  assign cpu_hold_o   = r_hold;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory the single-cycle CPU fetches from.
- Accepts a byte stream from a host link and assembles big-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the CPU in reset until the whole program is loaded; only then releases it to fetch from PC 0.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; header counts above this are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i holds a valid byte.
- byte_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs when valid and ready are both high.
- mem_we_o  output  1  one-cycle write strobe to instruction memory.
- mem_addr_o  output  32  byte address of the write.
- mem_data_o  output  32  word written.
- cpu_hold_o  output  1  1 = keep CPU in reset.
- done_o  output  1  program loaded, CPU released.
- err_o  output  1  load rejected; CPU stays held.

Behaviour:
- Reset values:
  - byte_ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0.
  - cpu_hold_o=1, done_o=0, err_o=0.
  - State HDR; byte counter 0; word counter 0.
- All outputs are registered.
- Byte order: the first byte of each 4-byte group goes to bits 31:24, the last to bits 7:0.
- A 2-bit byte counter wraps 3->0 on each completed word.
- States:
  - HDR: collect 4 bytes into count N.
    - N==0: go to DONE.
    - N>DEPTH_WORDS: go to ERR.
    - Otherwise: go to LOAD.
  - LOAD: each completed word is written, then the word counter k increments.
    - Write timing: 4th byte accepted at cycle t -> mem_we_o=1 at t+1, with mem_addr_o=BASE_ADDR+4*k and mem_data_o=word.
    - The next byte may be accepted at t+1; no bubble is required.
    - After the N-th write strobe, go to DONE.
  - DONE: byte_ready_o=0, done_o=1, cpu_hold_o=0. Terminal until rst_i.
  - ERR: byte_ready_o=0, err_o=1, cpu_hold_o=1. Terminal until rst_i.
- Timing of the last word:
  - Final word's 4th byte accepted at t.
  - mem_we_o at t+1.
  - done_o=1 and cpu_hold_o=0 at t+2, so the write lands before the first fetch.
- byte_valid_i while byte_ready_o=0 is ignored; no byte is consumed.
- byte_valid_i low mid-word: partial word is held indefinitely; no timeout.
- Word counter width is clog2(DEPTH_WORDS)+1 so that k==DEPTH_WORDS is representable.
- mem_addr_o does not wrap.
- rst_i at any time, including mid-word or mid-write:
  - Next cycle matches the reset values; the partial word is discarded.
  - A write strobe pending for the next cycle is cancelled.
  - Memory contents are not cleared.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - After the N-th data word, state CHK collects one further 4-byte word C.
  - C is compared to the XOR of the header word and all N data words.
  - Match -> DONE the cycle after C's 4th byte, or after the N-th write strobe if that is later.
  - Mismatch -> ERR.
  - C is never written to memory.
  - N==0 still requires C, which must equal the header (0).
- Undefined: no CHK state and no checksum register; the stream ends after the data words.

Decomposition:
- Package instr_loader_pkg holds:
  - the state enumeration (HDR, LOAD, CHK, DONE, ERR);
  - BYTES_PER_WORD=4;
  - the word-counter width function.
- Sub-module word_assembler: shift-in of 4 bytes with a 2-bit counter and a word_valid pulse. It is shared by the header, data and checksum phases.
- The FSM, address generation and hold/done logic stay in instr_loader.

Test Plan:
- Header 0x00000002, bytes DE AD BE EF 00 00 00 0C, valid held high -> two write strobes:
  - addr 0x0 data 0xDEADBEEF;
  - addr 0x4 data 0x0000000C;
  - done_o=1 and cpu_hold_o=0 exactly 2 cycles after the last byte.
- Header 0x00000000 -> done_o=1, no write strobe, byte_ready_o=0.
- Header DEPTH_WORDS+1 (257) -> err_o=1, cpu_hold_o stays 1, byte_ready_o=0, no writes.
- Randomly gapped byte_valid_i with N=3 -> same writes as the gap-free run; bytes offered while ready=0 after DONE are not consumed.
- rst_i pulsed after 2 bytes of word 1 -> outputs return to reset values; restreaming header 1 and 0x11223344 writes addr 0x0 = 0x11223344.
- With INSTR_LOADER_CHECKSUM_EN, N=1, word 0x00000005:
  - C=0x00000004 -> DONE;
  - C=0x00000000 -> ERR with cpu_hold_o=1.
